// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked instruction decode for the 9-bit core.
// Each accepted word becomes one registered control bundle. Around that sit a
// single-entry load-use scoreboard that stalls fetch, a sticky halt, and
// sticky illegal-encoding detection with a saturating hazard-stall counter.
module decode_stage #(
    parameter int NUM_REGS    = 12,
    parameter int INSTR_WIDTH = 9,
    parameter int REG_WIDTH   = 8,
    parameter int OP_WIDTH    = 4,
    parameter int LOAD_LAT    = 2,
    parameter int CNT_WIDTH   = 16,
    localparam int AW         = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OP_WIDTH-1:0]    alu_op,
    output logic [AW-1:0]          rs_addr,
    output logic [AW-1:0]          rt_addr,
    output logic [AW-1:0]          rd_addr,
    output logic [REG_WIDTH-1:0]   imm,
    output logic                   reg_read,
    output logic                   reg_write,
    output logic                   car_write,
    output logic                   sel_imm,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   mem2reg,
    output logic                   halt,
    output logic                   halted,
    output logic                   illegal,
    output logic [CNT_WIDTH-1:0]   stall_cnt
);

    localparam int PCW = $clog2(LOAD_LAT + 2);
    localparam logic [AW:0] NREGS = (AW + 1)'(NUM_REGS);

    typedef struct packed {
        logic [OP_WIDTH-1:0]  aluOp;
        logic [AW-1:0]        rs;
        logic [AW-1:0]        rt;
        logic [AW-1:0]        rd;
        logic [REG_WIDTH-1:0] imm;
        logic                 regRead;
        logic                 regWrite;
        logic                 carWrite;
        logic                 selImm;
        logic                 memRead;
        logic                 memWrite;
        logic                 mem2reg;
        logic                 halt;
    } bundle_t;

    logic [2:0]     w_op;
    logic [1:0]     w_c;
    logic [AW-1:0]  w_fa;
    logic [AW-1:0]  w_fb;
    logic [AW-1:0]  w_fc;
    bundle_t        w_dec;
    bundle_t        w_bundle;
    logic           w_usesRt;
    logic           w_usesRtOk;
    logic           w_badOp;
    logic           w_badIdx;
    logic           w_illegal;
    logic           w_hazard;
    logic           w_accept;
    logic           w_consume;

    bundle_t        r_bundle;
    logic           r_outValid;
    logic           r_halted;
    logic           r_illegal;
    logic [CNT_WIDTH-1:0] r_stallCnt;
    logic [PCW-1:0] r_pendCnt;
    logic [AW-1:0]  r_pendRd;

    assign w_op = instruction[8:6];
    assign w_c  = instruction[1:0];
    assign w_fa = AW'(instruction[5:4]);
    assign w_fb = AW'(instruction[3:2]);
    assign w_fc = AW'(instruction[1:0]);

    // Raw decode of the incoming word; register sums wrap modulo 2^AW.
    always_comb begin
        w_dec    = '0;
        w_usesRt = 1'b0;
        w_badOp  = 1'b0;
        case (w_op)
            3'b000: begin
                w_dec.regRead  = 1'b1;
                w_dec.regWrite = 1'b1;
                w_dec.rd       = AW'(11);
                if (w_c == 2'b11) begin
                    w_dec.aluOp = OP_WIDTH'(7);
                    w_dec.rs    = w_fa;
                end else begin
                    w_dec.aluOp = OP_WIDTH'(w_c);
                    w_dec.rs    = w_fa + AW'(4);
                    w_dec.rt    = w_fb;
                    w_usesRt    = 1'b1;
                end
            end
            3'b001: begin
                if (w_c[1]) begin
                    w_badOp = 1'b1;
                end else if (w_c[0] == 1'b0) begin
                    w_dec.aluOp    = OP_WIDTH'(6);
                    w_dec.rs       = w_fa + AW'(4);
                    w_dec.rd       = w_fb;
                    w_dec.regRead  = 1'b1;
                    w_dec.regWrite = 1'b1;
                    w_dec.memRead  = 1'b1;
                    w_dec.mem2reg  = 1'b1;
                end else begin
                    w_dec.aluOp    = OP_WIDTH'(6);
                    w_dec.rs       = w_fa + AW'(4);
                    w_dec.rt       = w_fb;
                    w_dec.regRead  = 1'b1;
                    w_dec.memWrite = 1'b1;
                    w_usesRt       = 1'b1;
                end
            end
            3'b010, 3'b100: begin
                w_dec.aluOp    = (w_op == 3'b010) ? OP_WIDTH'(4) : OP_WIDTH'(5);
                w_dec.rs       = w_fa + AW'(4);
                w_dec.rt       = w_fb;
                w_dec.rd       = w_fc + AW'(8);
                w_dec.regRead  = 1'b1;
                w_dec.regWrite = 1'b1;
                w_dec.carWrite = 1'b1;
                w_usesRt       = 1'b1;
            end
            3'b011: begin
                w_dec.aluOp    = OP_WIDTH'(4);
                w_dec.rs       = w_fb;
                w_dec.rd       = w_fa + AW'(8);
                w_dec.imm      = REG_WIDTH'(w_c);
                w_dec.selImm   = 1'b1;
                w_dec.regRead  = 1'b1;
                w_dec.regWrite = 1'b1;
            end
            3'b101: begin
                w_dec.aluOp    = OP_WIDTH'(6);
                w_dec.rs       = AW'(instruction[2:0]) + AW'(5);
                w_dec.rd       = AW'(instruction[5:3]) + AW'(1);
                w_dec.regRead  = 1'b1;
                w_dec.regWrite = 1'b1;
            end
            3'b110: begin
                w_dec.aluOp   = OP_WIDTH'(7);
                w_dec.rs      = w_fa + AW'(4);
                w_dec.rt      = w_fc + AW'(8);
                w_dec.rd      = w_fb;
                w_dec.regRead = 1'b1;
                w_usesRt      = 1'b1;
            end
            default: begin
                if (w_c == 2'b11) begin
                    w_dec.halt = 1'b1;
                end else begin
                    w_dec.aluOp    = OP_WIDTH'(w_c) + OP_WIDTH'(8);
                    w_dec.rs       = w_fa + AW'(4);
                    w_dec.rd       = w_fa + AW'(4);
                    w_dec.rt       = w_fb;
                    w_dec.regRead  = 1'b1;
                    w_dec.regWrite = 1'b1;
                    w_dec.carWrite = 1'b1;
                    w_usesRt       = 1'b1;
                end
            end
        endcase
    end

    // Flag out-of-range register indices and squash illegal words to zero.
    always_comb begin
        w_badIdx = (w_dec.regRead  && ({1'b0, w_dec.rs} >= NREGS)) ||
                   (w_usesRt       && ({1'b0, w_dec.rt} >= NREGS)) ||
                   (w_dec.regWrite && ({1'b0, w_dec.rd} >= NREGS));
        w_illegal  = w_badOp | w_badIdx;
        w_bundle   = w_illegal ? '0 : w_dec;
        w_usesRtOk = w_usesRt & ~w_illegal;
    end

    // Load-use hazard against the single pending load, then the handshake.
    always_comb begin
        w_hazard = (r_pendCnt != '0) && in_valid &&
                   ((w_bundle.regRead && (w_bundle.rs == r_pendRd)) ||
                    (w_usesRtOk && (w_bundle.rt == r_pendRd)));
        in_ready  = (~r_outValid | out_ready) & ~w_hazard & ~r_halted;
        w_accept  = in_valid & in_ready;
        w_consume = r_outValid & out_ready;
    end

    // Output register: load on accept, drop valid when consumed without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_bundle   <= '0;
        end else if (w_accept) begin
            r_outValid <= 1'b1;
            r_bundle   <= w_bundle;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Sticky halt/illegal status and the saturating hazard-stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
            r_stallCnt <= '0;
        end else begin
            if (w_accept && w_bundle.halt) r_halted <= 1'b1;
            if (w_accept && w_illegal) r_illegal <= 1'b1;
            if (w_hazard && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + CNT_WIDTH'(1);
        end
    end

    // Track the destination of the most recently consumed load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pendCnt <= '0;
            r_pendRd  <= '0;
        end else if (w_consume && r_bundle.memRead) begin
            r_pendCnt <= PCW'(LOAD_LAT);
            r_pendRd  <= r_bundle.rd;
        end else if (r_pendCnt != '0) begin
            r_pendCnt <= r_pendCnt - PCW'(1);
        end
    end

    assign out_valid = r_outValid;
    assign alu_op    = r_bundle.aluOp;
    assign rs_addr   = r_bundle.rs;
    assign rt_addr   = r_bundle.rt;
    assign rd_addr   = r_bundle.rd;
    assign imm       = r_bundle.imm;
    assign reg_read  = r_bundle.regRead;
    assign reg_write = r_bundle.regWrite;
    assign car_write = r_bundle.carWrite;
    assign sel_imm   = r_bundle.selImm;
    assign mem_read  = r_bundle.memRead;
    assign mem_write = r_bundle.memWrite;
    assign mem2reg   = r_bundle.mem2reg;
    assign halt      = r_bundle.halt;
    assign halted    = r_halted;
    assign illegal   = r_illegal;
    assign stall_cnt = r_stallCnt;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked instruction-decode stage for the 9-bit core. It sits between fetch and register-read. Each accepted instruction word becomes one registered control bundle, with deterministic zeros on every unused field. The block also adds three functions: a load-use hazard scoreboard that stalls fetch, a sticky halt that blocks further issue, and illegal-encoding detection with a stall-cycle counter.

## Interface
- NUM_REGS, 12, register-file depth; AW = $clog2(NUM_REGS)
- INSTR_WIDTH, 9, instruction width (fields below assume 9)
- REG_WIDTH, 8, imm width
- OP_WIDTH, 4, alu_op width
- LOAD_LAT, 2, cycles an LW destination stays pending after issue; 0 disables the scoreboard
- CNT_WIDTH, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word present
- in_ready  out  1  stage accepts the word this cycle
- instruction  in  INSTR_WIDTH  word from fetch
- out_valid  out  1  bundle valid
- out_ready  in  1  downstream accepts the bundle
- alu_op  out  OP_WIDTH  ALU operation
- rs_addr, rt_addr, rd_addr  out  AW each  register indices
- imm  out  REG_WIDTH  immediate
- reg_read, reg_write, car_write, sel_imm, mem_read, mem_write, mem2reg  out  1 each  control flags
- halt  out  1  bundle is HALT
- halted  out  1  sticky; HALT has been accepted
- illegal  out  1  sticky; an illegal word has been accepted
- stall_cnt  out  CNT_WIDTH  saturating count of hazard-stall cycles

## Operation
Fields: op = [8:6], a = [5:4], b = [3:2], c = [1:0]. Address sums are computed in AW bits, modulo 2^AW. Every field not listed below is 0.

Decode table:
- op 000, c = 00/01/10: AND/SLT/OR. alu 0/1/2; rs = a+4; rt = b; rd = 11; reg_read = 1, reg_write = 1; uses rt.
- op 000, c = 11: JR. alu 7; rs = a; rd = 11; reg_read = 1, reg_write = 1.
- op 001, c = 00: LW. alu 6; rs = a+4; rd = b; reg_read = 1, reg_write = 1, mem_read = 1, mem2reg = 1.
- op 001, c = 01: SW. alu 6; rs = a+4; rt = b; reg_read = 1, mem_write = 1; uses rt.
- op 001, c = 1x: illegal.
- op 010 / 100: ADD/SUB. alu 4/5; rs = a+4; rt = b; rd = c+8; reg_read = 1, reg_write = 1, car_write = 1; uses rt.
- op 011: ADDI. alu 4; rs = b; rd = a+8; imm = zero-extended c; sel_imm = 1; reg_read = 1, reg_write = 1.
- op 101: TR. alu 6; rs = [2:0]+5; rd = [5:3]+1; reg_read = 1, reg_write = 1.
- op 110: BEQ. alu 7; rs = a+4; rt = c+8; rd = b; reg_read = 1; uses rt.
- op 111, c = 00/01/10: SRL/SRA/SLL. alu 8/9/10; rs = rd = a+4; rt = b; reg_read = 1, reg_write = 1, car_write = 1; uses rt.
- op 111, c = 11: HALT. halt = 1; all other fields 0.

Illegal words:
- A word is illegal if it matches op 001 c = 1x, or if any produced index it uses is >= NUM_REGS (for example TR with [2:0] = 7 gives rs = 12).
- An illegal word is issued as an all-zero bundle: out_valid = 1, every other field 0. It also sets `illegal`.

Handshake:
- in_ready = (!out_valid | out_ready) & !hazard & !halted.
- Accept = in_valid & in_ready. The output register loads on accept.
- When the output is consumed with no accept in the same cycle, out_valid clears.
- out_valid and the bundle stay stable while out_valid & !out_ready.

Scoreboard:
- When an LW bundle is consumed (out_valid & out_ready & mem_read), the block stores pend_rd = rd_addr and sets pend_cnt = LOAD_LAT.
- pend_cnt decrements each cycle while nonzero.
- A later LW replaces pend_rd and reloads pend_cnt; only one load is tracked.
- hazard = pend_cnt != 0 & in_valid & ((reg_read & rs == pend_rd) | (uses_rt & rt == pend_rd)).
- stall_cnt increments on each hazard cycle and saturates at all-ones.

Halt:
- `halted` sets on accept of HALT.
- After that, in_ready = 0 until reset. The HALT bundle itself still drains normally.

## Timing
- Latency: 1 cycle from accept to out_valid. Back-to-back acceptance gives 1 word per cycle when out_ready = 1.
- The hazard is evaluated combinationally on the incoming word against the current pend state. An LW consumed in cycle N blocks a dependent word in cycles N+1 through N+LOAD_LAT.
- Reset, asynchronous, applies at any time including mid-stall. It clears:
  - out_valid and all bundle fields to 0;
  - halted and illegal to 0;
  - pend_cnt, pend_rd and stall_cnt to 0.
- After reset, in_ready = 1.
- Simultaneous consume and accept: the new word replaces the old bundle with out_valid held at 1.

## Test plan
- ADD 010_01_10_11 with out_ready = 1: next cycle out_valid = 1, rs = 5, rt = 2, rd = 11, alu 4, car_write = 1.
- Hold out_ready = 0 for 3 cycles after SUB: bundle is stable, in_ready = 0; releasing out_ready gives exactly one consume.
- LOAD_LAT = 2. Issue LW with rd = 2, then ADD with rt = 2: in_ready = 0 for 2 cycles, stall_cnt = 2, then ADD issues. A non-dependent ADDI does not stall.
- TR 101_000_111 (rs = 12) and 001_xx_xx_10: each gives an all-zero bundle with out_valid = 1, and illegal = 1 (sticky).
- HALT, then further valid words: halt = 1 bundle issues; halted = 1; in_ready stays 0 for more than 10 cycles.
- Assert rst_n low during a stall with halted = 1: all outputs read 0 immediately; after release in_ready = 1 and stall_cnt = 0.
